fifo: RTL and testbench
=======================

# fifo

Synchronous first-in/first-out buffer for `WIDTH`-bit words. It is the queue-ordered counterpart to the team's LIFO stack: writes enter at the tail and reads drain from the opposite end, so words leave in arrival order. It sits between a producer and a consumer in the same clock domain. It provides registered full/empty/count status and a one-cycle registered read port.

## Interface
- `WIDTH`, 8: data word width in bits.
- `ADDR_WIDTH`, 4: pointer width; depth `DEPTH = 2**ADDR_WIDTH` (16).

- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset (asserted when 0, sampled on `clk`).
- `push`  in  1  write request; `data_in` is captured when the push is accepted.
- `pop`  in  1  read request.
- `data_in`  in  `WIDTH`  write data.
- `data_out`  out  `WIDTH`  registered read data; holds its value between pops.
- `data_valid`  out  1  one-cycle pulse; `data_out` was updated this cycle.
- `full`  out  1  registered; `count == DEPTH`.
- `empty`  out  1  registered; `count == 0`.
- `count`  out  `ADDR_WIDTH+1`  registered occupancy, 0..`DEPTH`.

## Operation
- Storage: `DEPTH` x `WIDTH` register array, tail pointer `wr_ptr`, head pointer `rd_ptr`, both `ADDR_WIDTH` bits.
- Pointers wrap modulo `DEPTH` through natural overflow; `DEPTH-1 + 1 -> 0`.
- Accept rules, evaluated from the registered state in each cycle:
  - `push_ok = push & (~full | pop)`
  - `pop_ok = pop & ~empty`
- Push accepted: `mem[wr_ptr] <= data_in`, `wr_ptr++`.
- Pop accepted: `data_out <= mem[rd_ptr]`, `rd_ptr++`, `data_valid <= 1`.
- Occupancy update: `count += push_ok - pop_ok`. `full` and `empty` are recomputed from the next `count` and registered.
- Boundary cases:
  - Push while full and no pop: dropped. `mem`, pointers and `count` are unchanged.
  - Pop while empty: ignored. `data_out` holds its value and `data_valid` stays 0.
  - Push and pop while empty: only the push is accepted; `count` becomes 1. There is no fall-through.
  - Push and pop while full: both are accepted and `count` stays `DEPTH`. The read returns the old `mem[rd_ptr]`; the array is read-before-write even though `wr_ptr == rd_ptr`.
  - Push and pop at intermediate occupancy: both are accepted and `count` is unchanged.
- Reset, including when asserted mid-operation:
  - `wr_ptr`, `rd_ptr` and `count` go to 0.
  - `empty` goes to 1; `full` and `data_valid` go to 0.
  - `data_out` goes to all zeros.
  - Array contents are not cleared and are unobservable afterwards.
  - Requests in the cycle that reset is asserted are discarded.

## Timing
- Push to `empty` deassertion: 1 cycle; visible after the edge that accepts the push.
- Pop to `data_out` and `data_valid`: 1 cycle latency.
- Throughput: one push and one pop per cycle, sustained.
- `full`, `empty` and `count` change only on clock edges and are glitch-free.
- No combinational path from inputs to outputs.

## Configuration
- `FIFO_ERROR_FLAGS_EN`: when defined, adds two output ports.
  - `overflow` (1 bit): sticky; set on a cycle with `push & full & ~pop`.
  - `underflow` (1 bit): sticky; set on a cycle with `pop & empty`.
  - Both are cleared only by reset; their reset value is 0.
- When undefined, these ports and their logic are absent and the port list is exactly as listed above.
- Dropping or ignoring requests behaves identically with or without the macro.

## Structure
- Shared package/header `storage_pkg` holds the items common to `fifo` and the stack:
  - the `DEPTH` derivation from `ADDR_WIDTH`
  - the count-width constant `ADDR_WIDTH+1`
  - the reset-value constant for data registers
- Sub-module `fifo_ptr`: `ADDR_WIDTH`-bit wrapping pointer with synchronous active-low reset and an advance enable. It is instantiated twice, for tail and head.
- The array, count and flag logic stay in `fifo`.

## Test plan
- Reset then idle -> `empty=1`, `full=0`, `count=0`, `data_out=0x00`, `data_valid=0`. Pop while empty -> no change; `underflow=1` if `FIFO_ERROR_FLAGS_EN` is defined.
- Push 0x01..0x10 on 16 consecutive cycles, then pop 16 consecutive cycles -> `full=1` after the 16th push. `data_out` is 0x01..0x10 in order, each one cycle after its pop with `data_valid` pulsing. `empty=1` at the end.
- At full, push 0xAA without pop -> dropped; `count=16`; after draining, 0xAA never appears.
- At full (head word 0x01), push 0x55 and pop in the same cycle -> `data_out=0x01`, `count` stays 16. 0x55 emerges as the 16th word on drain.
- Wrap-around: 40 cycles of alternating push and pop with an incrementing pattern -> outputs match the input order across pointer wrap; `count` oscillates between 0 and 1.
- Push 0x10, 0x11, 0x12, then assert reset for one cycle during a push and pop -> `count=0`, `empty=1`, `data_out=0x00`. The next push/pop of 0x77 returns 0x77.

Source files
------------

// File: rtl/storage_pkg.sv
// Items shared by the FIFO and the LIFO stack: depth and count-width derivation
// from the pointer width, and the reset value used for data registers.
package storage_pkg;

  function automatic int unsigned depth_f(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // One extra bit so the occupancy can represent a completely full store.
  function automatic int unsigned count_width_f(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

  localparam logic DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping ADDR_WIDTH-bit pointer with synchronous active-low reset and an
// advance enable; used for both the tail (write) and head (read) of the FIFO.
module fifo_ptr #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adv_i,
  output logic [ADDR_WIDTH-1:0] ptr_o
);

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;

  // Natural overflow provides the modulo-DEPTH wrap.
  assign ptr_d = adv_i ? ptr_q + ADDR_WIDTH'(1) : ptr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO with registered status and a one-cycle registered read port.
// Define FIFO_ERROR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo
  import storage_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
`ifdef FIFO_ERROR_FLAGS_EN
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
`else
  output logic [ADDR_WIDTH:0]   count
`endif
);

  localparam int unsigned DEPTH = depth_f(ADDR_WIDTH);
  localparam int unsigned CW    = count_width_f(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q, valid_q;
  logic [WIDTH-1:0]      dout_q;
  logic                  push_ok, pop_ok;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign push_ok = push & (~full_q | pop);
  assign pop_ok  = pop & ~empty_q;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .adv_i (push_ok),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .adv_i (pop_ok),
    .ptr_o (rd_ptr)
  );

  // NOTE: the array has no reset; stale words are unreachable once the
  // pointers and count are cleared, and omitting it keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem_q[wr_ptr] <= data_in;
    end
  end

  // NOTE: non-blocking assignment makes the read below see the pre-edge array,
  // which gives read-before-write when push and pop hit the same slot at full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      valid_q <= 1'b0;
      dout_q  <= {WIDTH{DATA_RST_BIT}};
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_C);
      empty_q <= (count_d == '0);
      valid_q <= pop_ok;
      if (pop_ok) begin
        dout_q <= mem_q[rd_ptr];
      end
    end
  end

`ifdef FIFO_ERROR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | (push & full_q & ~pop);
      underflow_q <= underflow_q | (pop & empty_q);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: a reference queue predicts acceptance and read data,
// and expected reads are queued at stimulus time and compared as they emerge.
module tb_fifo;

  localparam int WIDTH = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
`ifdef FIFO_ERROR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  fifo #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty),
`ifdef FIFO_ERROR_FLAGS_EN
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
`else
    .count      (count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned      n_cmp = 0;
  int unsigned      n_bad = 0;
  logic [WIDTH-1:0] model[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_out = '0;
  logic             ovf_m = 1'b0;
  logic             unf_m = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic exp_valid);
    check("data_valid", 16'(data_valid), 16'(exp_valid));
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 16'(exp_q.size()), 16'd1);
      end else begin
        last_out = exp_q.pop_front();
      end
    end
    check("data_out", 16'(data_out), 16'(last_out));
    check("count", 16'(count), 16'(model.size()));
    check("full", 16'(full), 16'(model.size() == DEPTH));
    check("empty", 16'(empty), 16'(model.size() == 0));
`ifdef FIFO_ERROR_FLAGS_EN
    check("overflow", 16'(overflow), 16'(ovf_m));
    check("underflow", 16'(underflow), 16'(unf_m));
`endif
  endtask

  // Drive one cycle of requests (rst=0 asserts reset), predict, then check.
  task automatic step(input logic ps, input logic pp, input logic [WIDTH-1:0] d,
                      input logic rst);
    logic pop_ok;
    logic push_ok;
    pop_ok = 1'b0;
    push    = ps;
    pop     = pp;
    data_in = d;
    reset   = rst;
    if (!rst) begin
      model.delete();
      exp_q.delete();
      last_out = '0;
      ovf_m    = 1'b0;
      unf_m    = 1'b0;
    end else begin
      pop_ok  = pp && (model.size() > 0);
      push_ok = ps && ((model.size() < DEPTH) || pp);
      if (ps && !pp && model.size() == DEPTH) ovf_m = 1'b1;
      if (pp && model.size() == 0) unf_m = 1'b1;
      if (pop_ok) exp_q.push_back(model.pop_front());
      if (push_ok) model.push_back(d);
    end
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b1;
    check_outputs(pop_ok);
  endtask

  initial begin
    // Reset, idle, then pop while empty
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1);

    // Fill 0x01..0x10, drain in order
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b1);

    // Refill, drop 0xAA at full, push 0x55 with pop at full, drain
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b1);
    step(1'b1, 1'b0, 8'hAA, 1'b1);
    step(1'b1, 1'b1, 8'h55, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b1);
    check("last_drained", 16'(data_out), 16'h0055);

    // Alternating push/pop across pointer wrap
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b1);
      else            step(1'b0, 1'b1, 8'h00, 1'b1);
    end

    // Simultaneous push and pop while empty: push only
    step(1'b1, 1'b1, 8'h33, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1);

    // Reset mid-operation with requests pending
    step(1'b1, 1'b0, 8'h10, 1'b1);
    step(1'b1, 1'b0, 8'h11, 1'b1);
    step(1'b1, 1'b0, 8'h12, 1'b1);
    step(1'b1, 1'b1, 8'h13, 1'b0);
    step(1'b1, 1'b0, 8'h77, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    check("post_reset_word", 16'(data_out), 16'h0077);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
